// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//   Conditions the raw confirm/clear push-buttons for the top-level control FSM.
//   Each channel is a synchroniser, then a debounce FSM, then a press pulse.
//   Clear wins over confirm. A button held through reset never produces a pulse.
//
//   Ports
//     sysClk         in   system clock, rising edge
//     iRst_n         in   synchronous active-low reset
//     btn_confirm_i  in   raw confirm button (async, bouncing, active-high)
//     btn_clear_i    in   raw clear button   (async, bouncing, active-high)
//     confirm        out  one-cycle pulse on an accepted confirm press
//     clear          out  one-cycle pulse on an accepted clear press
//     confirm_level  out  debounced confirm level
//     clear_level    out  debounced clear level
// ----------------------------------------------------------------------------

// One debounce channel: synchroniser plus debounce FSM.
// pulse_d_o is the next-cycle press pulse; the top registers it after
// arbitration so the port pulse lands on the same edge the FSM enters HELD.
module button_conditioner_chan #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20,
   parameter int SYNC_STAGES     = 2
) (
   input  logic sysClk,
   input  logic iRst_n,
   input  logic btn_i,
   output logic pulse_d_o,
   output logic level_o
);

   typedef enum logic [2:0] {
      BOOT,
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   state_t                 state_q, state_d;
   logic                   s;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
   assign s      = sync_q[SYNC_STAGES-1];

   always_ff @(posedge sysClk) begin
      if (!iRst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         state_q <= BOOT;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_d_o = 1'b0;
      case (state_q)
         // Arm only after a full debounce window of stable low, so a
         // button held through reset must be released first.
         BOOT: begin
            if (s) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE: begin
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d   = HELD;
               cnt_d     = '0;
               pulse_d_o = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = BOOT;
            cnt_d   = '0;
         end
      endcase
   end

   // Decoded straight from the state register, so still glitch-free.
   assign level_o = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20,
   parameter int SYNC_STAGES     = 2
) (
   input  logic sysClk,
   input  logic iRst_n,
   input  logic btn_confirm_i,
   input  logic btn_clear_i,
   output logic confirm,
   output logic clear,
   output logic confirm_level,
   output logic clear_level
);

   localparam int NUM_CH = 2;
   localparam int CH_CONF = 0;
   localparam int CH_CLR  = 1;

   logic [NUM_CH-1:0] btn, pulse_d, level;
   logic              confirm_q, confirm_d;
   logic              clear_q, clear_d;

   assign btn[CH_CONF] = btn_confirm_i;
   assign btn[CH_CLR]  = btn_clear_i;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      button_conditioner_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_chan (
         .sysClk    (sysClk),
         .iRst_n    (iRst_n),
         .btn_i     (btn[g]),
         .pulse_d_o (pulse_d[g]),
         .level_o   (level[g])
      );
   end

   // Confirm is dropped, not deferred, when clear fires on the same edge or
   // clear is already held; the two pulses are therefore mutually exclusive.
   assign clear_d   = pulse_d[CH_CLR];
   assign confirm_d = pulse_d[CH_CONF] & ~pulse_d[CH_CLR] & ~level[CH_CLR];

   always_ff @(posedge sysClk) begin
      if (!iRst_n) begin
         confirm_q <= 1'b0;
         clear_q   <= 1'b0;
      end else begin
         confirm_q <= confirm_d;
         clear_q   <= clear_d;
      end
   end

   assign confirm       = confirm_q;
   assign clear         = clear_q;
   assign confirm_level = level[CH_CONF];
   assign clear_level   = level[CH_CLR];

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
//   Inputs change 1 ns after a rising edge; outputs are sampled at the same
//   point, so a press set after tick 0 shows its pulse after tick 11
//   (first sampled at the next edge, plus 2 sync stages plus 8 debounce cycles).
// ----------------------------------------------------------------------------
module tb_button_conditioner;

   logic sysClk = 1'b0;
   logic iRst_n;
   logic btn_confirm_i, btn_clear_i;
   logic confirm, clear, confirm_level, clear_level;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-window observation stats, cleared by clr_stats().
   int t;
   int conf_cnt, clr_cnt, both_cnt;
   int conf_first, clr_first, conf_lvl_first, clr_lvl_first;

   always #5 sysClk = ~sysClk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (8),
      .CNT_W           (4),
      .SYNC_STAGES     (2)
   ) dut (
      .sysClk        (sysClk),
      .iRst_n        (iRst_n),
      .btn_confirm_i (btn_confirm_i),
      .btn_clear_i   (btn_clear_i),
      .confirm       (confirm),
      .clear         (clear),
      .confirm_level (confirm_level),
      .clear_level   (clear_level)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      t = 0;
      conf_cnt = 0; clr_cnt = 0; both_cnt = 0;
      conf_first = -1; clr_first = -1;
      conf_lvl_first = -1; clr_lvl_first = -1;
   endtask

   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sysClk);
         #1;
         t++;
         if (confirm === 1'b1) begin
            conf_cnt++;
            if (conf_first < 0) conf_first = t;
         end
         if (clear === 1'b1) begin
            clr_cnt++;
            if (clr_first < 0) clr_first = t;
         end
         if (confirm === 1'b1 && clear === 1'b1) both_cnt++;
         if (confirm_level === 1'b1 && conf_lvl_first < 0) conf_lvl_first = t;
         if (clear_level === 1'b1 && clr_lvl_first < 0) clr_lvl_first = t;
      end
   endtask

   initial begin
      iRst_n        = 1'b0;
      btn_confirm_i = 1'b0;
      btn_clear_i   = 1'b0;
      clr_stats();

      // Reset state
      watch(3);
      chk("rst_confirm", int'(confirm), 0);
      chk("rst_clear", int'(clear), 0);
      chk("rst_conf_lvl", int'(confirm_level), 0);
      chk("rst_clr_lvl", int'(clear_level), 0);
      iRst_n = 1'b1;
      watch(12);   // BOOT arms after 8 stable-low cycles

      // 1. Clean confirm press held 40 cycles
      clr_stats();
      btn_confirm_i = 1'b1;
      watch(10);
      chk("t1_lvl_before", int'(confirm_level), 0);
      watch(1);
      chk("t1_lvl_at_pulse", int'(confirm_level), 1);
      watch(29);
      chk("t1_conf_cnt", conf_cnt, 1);
      chk("t1_conf_first", conf_first, 11);
      chk("t1_clr_cnt", clr_cnt, 0);
      btn_confirm_i = 1'b0;
      watch(10);
      chk("t1_lvl_release_wait", int'(confirm_level), 1);
      watch(1);
      chk("t1_lvl_released", int'(confirm_level), 0);
      watch(4);

      // 2. Bounce 1,0,1,1,0 (3 cycles each), then steady 1
      clr_stats();
      btn_confirm_i = 1'b1; watch(3);
      btn_confirm_i = 1'b0; watch(3);
      btn_confirm_i = 1'b1; watch(6);
      btn_confirm_i = 1'b0; watch(3);
      watch(2);   // flush the sync pipeline before judging the bounce
      chk("t2_bounce_conf_cnt", conf_cnt, 0);
      chk("t2_bounce_lvl", conf_lvl_first, -1);
      clr_stats();
      btn_confirm_i = 1'b1;
      watch(20);
      chk("t2_conf_cnt", conf_cnt, 1);
      chk("t2_conf_first", conf_first, 11);
      btn_confirm_i = 1'b0;
      watch(15);

      // 3. Simultaneous press
      clr_stats();
      btn_confirm_i = 1'b1;
      btn_clear_i   = 1'b1;
      watch(20);
      chk("t3_clr_cnt", clr_cnt, 1);
      chk("t3_clr_first", clr_first, 11);
      chk("t3_conf_cnt", conf_cnt, 0);
      chk("t3_conf_lvl_first", conf_lvl_first, 11);
      chk("t3_clr_lvl_first", clr_lvl_first, 11);
      btn_confirm_i = 1'b0;
      btn_clear_i   = 1'b0;
      watch(15);

      // 4. Confirm pressed while clear is held
      clr_stats();
      btn_clear_i = 1'b1;
      watch(5);
      btn_confirm_i = 1'b1;
      watch(25);
      chk("t4_clr_cnt", clr_cnt, 1);
      chk("t4_clr_first", clr_first, 11);
      chk("t4_conf_cnt", conf_cnt, 0);
      chk("t4_conf_lvl_first", conf_lvl_first, 16);
      btn_confirm_i = 1'b0;
      btn_clear_i   = 1'b0;
      watch(15);

      // 5. Clear held through reset: no pulse until released and re-pressed
      btn_clear_i = 1'b1;
      iRst_n = 1'b0;
      watch(3);
      iRst_n = 1'b1;
      clr_stats();
      watch(30);
      chk("t5_held_clr_cnt", clr_cnt, 0);
      chk("t5_held_clr_lvl", int'(clear_level), 0);
      btn_clear_i = 1'b0;
      watch(10);  // exactly enough for BOOT to arm
      chk("t5_release_clr_cnt", clr_cnt, 0);
      clr_stats();
      btn_clear_i = 1'b1;
      watch(20);
      chk("t5_clr_cnt", clr_cnt, 1);
      chk("t5_clr_first", clr_first, 11);
      btn_clear_i = 1'b0;
      watch(15);

      // 6. Reset pulse while confirm is in PRESS_WAIT with cnt=5
      clr_stats();
      btn_confirm_i = 1'b1;
      watch(8);
      iRst_n = 1'b0;
      watch(1);
      chk("t6_rst_confirm", int'(confirm), 0);
      chk("t6_rst_conf_lvl", int'(confirm_level), 0);
      iRst_n = 1'b1;
      watch(20);
      chk("t6_held_conf_cnt", conf_cnt, 0);
      btn_confirm_i = 1'b0;
      watch(12);
      clr_stats();
      btn_confirm_i = 1'b1;
      watch(20);
      chk("t6_rearm_conf_cnt", conf_cnt, 1);
      chk("t6_rearm_conf_first", conf_first, 11);
      chk("t6_both_never", both_cnt, 0);
      btn_confirm_i = 1'b0;
      watch(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
